// File: rtl/pixelstream_fifo.sv
// Elastic pixel buffer with optional horizontal pixel doubling, flush and fill-level status.
// Define PIXELSTREAM_FIFO_UNDERRUN_EN to add the saturating underrun_cnt output.
module pixelstream_fifo #(
    parameter int PIXEL_W   = 8,
    parameter int DEPTH     = 16,
    parameter int AE_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       dbl,
    input  logic                       in_write,
    input  logic [PIXEL_W-1:0]         in_pixel,
    output logic                       in_strobe,
    output logic                       out_write,
    output logic [PIXEL_W-1:0]         out_pixel,
    input  logic                       out_strobe,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_empty
`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
    ,
    output logic [15:0]                underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DEPTH-1:0][PIXEL_W-1:0] mem_q, mem_d;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                 level_q, level_d;
    logic                          phase_q, phase_d;
    logic                          push, pop, out_xfer;

    assign in_strobe    = reset_n & (level_q != LVL_FULL) & ~flush;
    assign out_write    = (level_q != '0);
    assign out_pixel    = out_write ? mem_q[rd_ptr_q] : '0;
    assign level        = level_q;
    assign almost_empty = (level_q <= LVL_AE);

    assign push     = in_write & in_strobe;
    assign out_xfer = out_write & out_strobe;
    // In doubling mode the head pixel is retired only on its second transfer.
    assign pop      = out_xfer & (~dbl | phase_q);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        phase_d  = 1'b0;
        if (push) begin
            mem_d[wr_ptr_q] = in_pixel;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (dbl) begin
            phase_d = out_xfer ? ~phase_q : phase_q;
        end
        // The consumer still sees a transfer during flush; internal state just restarts.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            phase_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
        end
    end

    // Storage needs no reset: out_pixel is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (out_strobe && (level_q == '0) && !flush && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_pixelstream_fifo.sv
// Directed self-checking bench for pixelstream_fifo (default parameters).
// Underrun counter checks are compiled in when PIXELSTREAM_FIFO_UNDERRUN_EN is defined.
module tb_pixelstream_fifo;

    logic       clk = 1'b0;
    logic       reset_n, flush, dbl, in_write, out_strobe;
    logic [7:0] in_pixel;
    logic       in_strobe, out_write, almost_empty;
    logic [7:0] out_pixel;
    logic [4:0] level;
`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixelstream_fifo #(.PIXEL_W(8), .DEPTH(16), .AE_THRESH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .dbl          (dbl),
        .in_write     (in_write),
        .in_pixel     (in_pixel),
        .in_strobe    (in_strobe),
        .out_write    (out_write),
        .out_pixel    (out_pixel),
        .out_strobe   (out_strobe),
        .level        (level),
        .almost_empty (almost_empty)
`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        out_strobe = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_write = 1'b1;
            in_pixel = base + 8'(i);
            tick();
        end
        in_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; dbl = 1'b0;
        in_write = 1'b0; in_pixel = '0; out_strobe = 1'b0;
        tick(); tick();
        chk("rst_in_strobe", 32'(in_strobe), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_out_write", 32'(out_write), 32'h0);
        chk("rst_out_pixel", 32'(out_pixel), 32'h0);
        chk("rst_almost_empty", 32'(almost_empty), 32'h1);
`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
        chk("rst_underrun", 32'(underrun_cnt), 32'h0);
`endif
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_strobe", 32'(in_strobe), 32'h1);

        // Fill to DEPTH, then try a 17th write
        push_n(16, 8'h00);
        chk("full_level", 32'(level), 32'd16);
        chk("full_in_strobe", 32'(in_strobe), 32'h0);
        chk("full_almost_empty", 32'(almost_empty), 32'h0);
        in_write = 1'b1; in_pixel = 8'h10;
        tick();
        in_write = 1'b0;
        chk("full_17th_dropped", 32'(level), 32'd16);

        // Drain in order
        out_strobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_pixel", 32'(out_pixel), 32'(i));
            chk("drain_level", 32'(level), 32'(16 - i));
            chk("drain_ae", 32'(almost_empty), (16 - i <= 4) ? 32'h1 : 32'h0);
            tick();
        end
        out_strobe = 1'b0;
        chk("drain_out_write", 32'(out_write), 32'h0);
        chk("drain_level_end", 32'(level), 32'h0);
        chk("drain_out_pixel_end", 32'(out_pixel), 32'h0);

        // Pixel doubling
        dbl = 1'b1;
        in_write = 1'b1; in_pixel = 8'hA1; tick();
        in_pixel = 8'hB2; tick();
        in_write = 1'b0;
        out_strobe = 1'b1;
        chk("dbl_0", 32'(out_pixel), 32'hA1); chk("dbl_l0", 32'(level), 32'd2); tick();
        chk("dbl_1", 32'(out_pixel), 32'hA1); chk("dbl_l1", 32'(level), 32'd2); tick();
        chk("dbl_2", 32'(out_pixel), 32'hB2); chk("dbl_l2", 32'(level), 32'd1); tick();
        chk("dbl_3", 32'(out_pixel), 32'hB2); chk("dbl_l3", 32'(level), 32'd1); tick();
        out_strobe = 1'b0; dbl = 1'b0;
        chk("dbl_empty", 32'(out_write), 32'h0);

        // Full buffer with both sides active: first cycle pops only
        push_n(16, 8'h20);
        in_write = 1'b1; out_strobe = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_pixel = 8'h40 + 8'(k);
            #1;
            chk("fb_in_strobe", 32'(in_strobe), (k == 0) ? 32'h0 : 32'h1);
            chk("fb_level", 32'(level), (k == 0) ? 32'd16 : 32'd15);
            chk("fb_pixel", 32'(out_pixel), 32'h20 + 32'(k));
            tick();
        end
        in_write = 1'b0;
        chk("fb_level_end", 32'(level), 32'd15);
        for (int j = 0; j < 15; j++) begin
            chk("fb_drain", 32'(out_pixel), (j < 11) ? 32'h25 + 32'(j) : 32'h41 + 32'(j - 11));
            tick();
        end
        out_strobe = 1'b0;
        chk("fb_empty", 32'(out_write), 32'h0);

        // Half buffer, both sides active: level holds
        push_n(8, 8'h50);
        in_write = 1'b1; out_strobe = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_pixel = 8'h60 + 8'(k);
            #1;
            chk("hb_level", 32'(level), 32'd8);
            chk("hb_pixel", 32'(out_pixel), 32'h50 + 32'(k));
            tick();
        end
        in_write = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("hb_drain", 32'(out_pixel), (j < 3) ? 32'h55 + 32'(j) : 32'h60 + 32'(j - 3));
            tick();
        end
        out_strobe = 1'b0;
        chk("hb_empty", 32'(level), 32'h0);

`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
        out_strobe = 1'b1; tick(); tick(); out_strobe = 1'b0;
        chk("ur_two", 32'(underrun_cnt), 32'd2);
`endif

        // Flush at level 10 with a concurrent write
        push_n(10, 8'h70);
        chk("fl_level_pre", 32'(level), 32'd10);
        flush = 1'b1; in_write = 1'b1; in_pixel = 8'hEE; out_strobe = 1'b1;
        #1;
        chk("fl_in_strobe", 32'(in_strobe), 32'h0);
        chk("fl_seen_pixel", 32'(out_pixel), 32'h70);
        tick();
        flush = 1'b0; in_write = 1'b0; out_strobe = 1'b0;
        chk("fl_level", 32'(level), 32'h0);
        chk("fl_out_write", 32'(out_write), 32'h0);
        chk("fl_out_pixel", 32'(out_pixel), 32'h0);
`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
        chk("fl_underrun_kept", 32'(underrun_cnt), 32'd2);
`endif
        push_n(1, 8'h33);
        chk("fl_next_valid", 32'(out_write), 32'h1);
        chk("fl_next_pixel", 32'(out_pixel), 32'h33);
        out_strobe = 1'b1; tick(); out_strobe = 1'b0;

        // Reset mid-stream
        push_n(10, 8'h80);
        reset_n = 1'b0; in_write = 1'b1; in_pixel = 8'hDD;
        #1;
        chk("mr_in_strobe", 32'(in_strobe), 32'h0);
        tick();
        reset_n = 1'b1; in_write = 1'b0;
        chk("mr_level", 32'(level), 32'h0);
        chk("mr_out_write", 32'(out_write), 32'h0);
        chk("mr_out_pixel", 32'(out_pixel), 32'h0);
`ifdef PIXELSTREAM_FIFO_UNDERRUN_EN
        chk("mr_underrun", 32'(underrun_cnt), 32'h0);

        // Underrun counting and saturation
        out_strobe = 1'b1;
        repeat (3) tick();
        chk("ur_three", 32'(underrun_cnt), 32'd3);
        repeat (65531) tick();
        chk("ur_fffe", 32'(underrun_cnt), 32'hFFFE);
        repeat (3) tick();
        chk("ur_sat", 32'(underrun_cnt), 32'hFFFF);
        out_strobe = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
